alu_pipe: RTL and testbench

ALU_PIPE -- requirements
Module: alu_pipe

---
 rtl/alu_pipe.sv | 142 ++++++++++++++
 tb/tb_alu_pipe.sv | 214 +++++++++++++++++++++
 2 files changed

// File: rtl/alu_pipe.sv
// alu_pipe: two-stage valid/ready ALU pipeline (add, sub, and, or, sll, sra, slt).
// Stage 1 registers the operands, opcode and shift amount. Stage 2 registers
// the result and the comparison and overflow flags.
// Optional feature: define ALU_PIPE_STICKY_OVF_EN to add a sticky_overflow output.
// sticky_overflow sets when a result with overflow=1 is transferred out, and
// holds until reset.
module alu_pipe #(
    parameter int unsigned WIDTH   = 32,
    parameter int unsigned SHAMT_W = 5
) (
    input  logic               clock,
    input  logic               reset,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [WIDTH-1:0]   data_operandA,
    input  logic [WIDTH-1:0]   data_operandB,
    input  logic [4:0]         ctrl_ALUopcode,
    input  logic [SHAMT_W-1:0] ctrl_shiftamt,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [WIDTH-1:0]   data_result,
    output logic               isNotEqual,
    output logic               isLessThan,
    output logic               overflow
`ifdef ALU_PIPE_STICKY_OVF_EN
    ,
    output logic               sticky_overflow
`endif
);

    localparam logic [4:0] OP_ADD = 5'b00000;
    localparam logic [4:0] OP_SUB = 5'b00001;
    localparam logic [4:0] OP_AND = 5'b00010;
    localparam logic [4:0] OP_OR  = 5'b00011;
    localparam logic [4:0] OP_SLL = 5'b00100;
    localparam logic [4:0] OP_SRA = 5'b00101;
    localparam logic [4:0] OP_SLT = 5'b00110;

    logic               s1_valid;
    logic [WIDTH-1:0]   s1_a;
    logic [WIDTH-1:0]   s1_b;
    logic [4:0]         s1_op;
    logic [SHAMT_W-1:0] s1_sh;

    logic               s2_adv;
    logic [WIDTH:0]     diff_c;
    logic [WIDTH-1:0]   sum_c;
    logic [SHAMT_W-1:0] amt_c;
    logic signed [WIDTH-1:0] a_signed_c;
    logic [WIDTH-1:0]   res_c;
    logic               ovf_c;
    logic               ne_c;
    logic               lt_c;

    // The output stage moves when it is empty or its result is being taken.
    // Stage 1 feeds it on that same cycle, so there is no extra bubble.
    assign s2_adv   = !out_valid || out_ready;
    assign in_ready = !reset && (!s1_valid || s2_adv);

    // Stage 1: capture the operation on an input transfer
    always_ff @(posedge clock) begin
        if (reset) begin
            s1_valid <= 1'b0;
            s1_a     <= '0;
            s1_b     <= '0;
            s1_op    <= '0;
            s1_sh    <= '0;
        end else if (in_ready) begin
            s1_valid <= in_valid;
            if (in_valid) begin
                s1_a  <= data_operandA;
                s1_b  <= data_operandB;
                s1_op <= ctrl_ALUopcode;
                s1_sh <= ctrl_shiftamt;
            end
        end
    end

    // Execute: result and flags from the stage-1 operation
    always_comb begin
        res_c      = '0;
        ovf_c      = 1'b0;
        a_signed_c = s1_a;
        // The sign-extended difference keeps the true sign even when A-B overflows.
        diff_c     = {s1_a[WIDTH-1], s1_a} - {s1_b[WIDTH-1], s1_b};
        sum_c      = s1_a + s1_b;
        amt_c      = SHAMT_W'(32'(s1_sh) % WIDTH);
        ne_c       = |diff_c[WIDTH-1:0];
        lt_c       = diff_c[WIDTH];
        case (s1_op)
            OP_ADD: begin
                res_c = sum_c;
                ovf_c = (s1_a[WIDTH-1] == s1_b[WIDTH-1]) && (sum_c[WIDTH-1] != s1_a[WIDTH-1]);
            end
            OP_SUB: begin
                res_c = diff_c[WIDTH-1:0];
                ovf_c = (s1_a[WIDTH-1] != s1_b[WIDTH-1]) &&
                        (diff_c[WIDTH-1] != s1_a[WIDTH-1]);
            end
            OP_AND:  res_c = s1_a & s1_b;
            OP_OR:   res_c = s1_a | s1_b;
            OP_SLL:  res_c = s1_a << amt_c;
            OP_SRA:  res_c = a_signed_c >>> amt_c;
            OP_SLT:  res_c = WIDTH'(lt_c);
            default: begin
                res_c = '0;
                ovf_c = 1'b0;
            end
        endcase
    end

    // Stage 2: register result and flags; hold them while stalled
    always_ff @(posedge clock) begin
        if (reset) begin
            out_valid   <= 1'b0;
            data_result <= '0;
            isNotEqual  <= 1'b0;
            isLessThan  <= 1'b0;
            overflow    <= 1'b0;
        end else if (s2_adv) begin
            out_valid <= s1_valid;
            if (s1_valid) begin
                data_result <= res_c;
                isNotEqual  <= ne_c;
                isLessThan  <= lt_c;
                overflow    <= ovf_c;
            end
        end
    end

`ifdef ALU_PIPE_STICKY_OVF_EN
    // Sticky overflow: set when an overflowing result is handed downstream
    always_ff @(posedge clock) begin
        if (reset) begin
            sticky_overflow <= 1'b0;
        end else if (out_valid && out_ready && overflow) begin
            sticky_overflow <= 1'b1;
        end
    end
`endif

endmodule

// File: tb/tb_alu_pipe.sv
// tb_alu_pipe: directed self-checking bench for alu_pipe.
// It drives a WIDTH=32 instance and a WIDTH=16 instance.
module tb_alu_pipe;

    localparam logic [4:0] ADD = 5'b00000;
    localparam logic [4:0] SUB = 5'b00001;
    localparam logic [4:0] AND = 5'b00010;
    localparam logic [4:0] OR  = 5'b00011;
    localparam logic [4:0] SLL = 5'b00100;
    localparam logic [4:0] SRA = 5'b00101;
    localparam logic [4:0] SLT = 5'b00110;

    logic        clock = 1'b0;
    logic        reset;

    logic        in_valid, in_ready, out_valid, out_ready;
    logic [31:0] a, b, result;
    logic [4:0]  opc, sh;
    logic        ne, lt, ovf;
`ifdef ALU_PIPE_STICKY_OVF_EN
    logic        sticky;
`endif

    logic        iv16, ir16, ov16, or16;
    logic [15:0] a16, b16, result16;
    logic [4:0]  opc16;
    logic [3:0]  sh16;
    logic        ne16, lt16, ovf16;

    int total = 0;
    int bad   = 0;

    alu_pipe #(.WIDTH(32), .SHAMT_W(5)) dut (
        .clock(clock), .reset(reset),
        .in_valid(in_valid), .in_ready(in_ready),
        .data_operandA(a), .data_operandB(b),
        .ctrl_ALUopcode(opc), .ctrl_shiftamt(sh),
        .out_valid(out_valid), .out_ready(out_ready),
        .data_result(result), .isNotEqual(ne), .isLessThan(lt), .overflow(ovf)
`ifdef ALU_PIPE_STICKY_OVF_EN
        , .sticky_overflow(sticky)
`endif
    );

    alu_pipe #(.WIDTH(16), .SHAMT_W(4)) dut16 (
        .clock(clock), .reset(reset),
        .in_valid(iv16), .in_ready(ir16),
        .data_operandA(a16), .data_operandB(b16),
        .ctrl_ALUopcode(opc16), .ctrl_shiftamt(sh16),
        .out_valid(ov16), .out_ready(or16),
        .data_result(result16), .isNotEqual(ne16), .isLessThan(lt16), .overflow(ovf16)
`ifdef ALU_PIPE_STICKY_OVF_EN
        , .sticky_overflow()
`endif
    );

    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    // One operation on the 32-bit instance: accept, then wait for the result stage
    task automatic op32(input logic [31:0] va, input logic [31:0] vb,
                        input logic [4:0] vop, input logic [4:0] vsh);
        in_valid = 1'b1; a = va; b = vb; opc = vop; sh = vsh;
        tick();
        in_valid = 1'b0;
        tick();
    endtask

    task automatic expect32(input string tag, input logic [31:0] er, input logic eo,
                            input logic el, input logic en);
        check({tag, ".valid"}, 64'(out_valid), 64'(1));
        check({tag, ".result"}, 64'(result), 64'(er));
        check({tag, ".ovf"}, 64'(ovf), 64'(eo));
        check({tag, ".lt"}, 64'(lt), 64'(el));
        check({tag, ".ne"}, 64'(ne), 64'(en));
    endtask

    task automatic op16(input logic [15:0] va, input logic [15:0] vb, input logic [4:0] vop);
        iv16 = 1'b1; a16 = va; b16 = vb; opc16 = vop; sh16 = 4'd0;
        tick();
        iv16 = 1'b0;
        tick();
    endtask

    initial begin
        // Reset with an operation offered: it must not be taken
        reset = 1'b1; out_ready = 1'b1;
        in_valid = 1'b1; a = 32'h7FFF_FFFF; b = 32'h1; opc = ADD; sh = 5'd0;
        iv16 = 1'b0; or16 = 1'b1; a16 = '0; b16 = '0; opc16 = ADD; sh16 = '0;
        tick(); tick();
        check("rst.valid", 64'(out_valid), 64'(0));
        check("rst.result", 64'(result), 64'(0));
        check("rst.flags", 64'({ovf, lt, ne}), 64'(0));
        reset = 1'b0; in_valid = 1'b0;
        #1;
        check("rst.in_ready", 64'(in_ready), 64'(1));
        tick(); tick();
        check("rst.no_transfer", 64'(out_valid), 64'(0));

        // Arithmetic and boundary vectors
        op32(32'h7FFF_FFFF, 32'h0000_0001, ADD, 5'd0);
        expect32("add_ovf", 32'h8000_0000, 1'b1, 1'b0, 1'b1);
        op32(32'h8000_0000, 32'h0000_0001, SUB, 5'd0);
        expect32("sub_ovf", 32'h7FFF_FFFF, 1'b1, 1'b1, 1'b1);
`ifdef ALU_PIPE_STICKY_OVF_EN
        check("sticky.set", 64'(sticky), 64'(1));
`endif
        op32(32'hF000_0000, 32'h0, SRA, 5'd4);
        expect32("sra", 32'hFF00_0000, 1'b0, 1'b1, 1'b1);
        op32(32'h0000_0001, 32'h0, SLL, 5'd31);
        expect32("sll31", 32'h8000_0000, 1'b0, 1'b0, 1'b1);
        op32(32'h1234_5678, 32'h1234_5678, SLL, 5'd0);
        expect32("sll0", 32'h1234_5678, 1'b0, 1'b0, 1'b0);
        op32(32'hFFFF_FFFF, 32'h0000_0001, SLT, 5'd0);
        expect32("slt", 32'h0000_0001, 1'b0, 1'b1, 1'b1);
        op32(32'hA5A5_F0F0, 32'hA5A5_F0F0, AND, 5'd0);
        expect32("and_eq", 32'hA5A5_F0F0, 1'b0, 1'b0, 1'b0);
        op32(32'h0000_0F00, 32'h0000_00F0, OR, 5'd0);
        expect32("or", 32'h0000_0FF0, 1'b0, 1'b0, 1'b1);
        op32(32'h7FFF_FFFF, 32'h0000_0001, 5'b11111, 5'd3);
        expect32("illegal", 32'h0, 1'b0, 1'b0, 1'b1);

        // Back-to-back stream of 8 adds: A=c, B=16*c, result 17*c
        for (int c = 0; c < 10; c++) begin
            if (c < 8) begin
                in_valid = 1'b1; a = 32'(c); b = 32'(c * 16); opc = ADD; sh = 5'd0;
            end else begin
                in_valid = 1'b0;
            end
            tick();
            if (c >= 1 && c <= 8) begin
                check($sformatf("stream%0d.valid", c - 1), 64'(out_valid), 64'(1));
                check($sformatf("stream%0d.result", c - 1), 64'(result), 64'((c - 1) * 17));
            end else begin
                check($sformatf("stream.idle%0d", c), 64'(out_valid), 64'(0));
            end
        end

        // Backpressure: three ops, downstream stalled for three edges
        out_ready = 1'b0;
        in_valid = 1'b1; a = 32'h1; b = 32'h1000; opc = ADD;
        tick();
        a = 32'h2;
        #1;
        check("stall.ready_op2", 64'(in_ready), 64'(1));
        tick();
        a = 32'h3;
        #1;
        check("stall.full", 64'(in_ready), 64'(0));
        check("stall.res0", 64'(result), 64'(32'h1001));
        tick();
        check("stall.hold1.valid", 64'(out_valid), 64'(1));
        check("stall.hold1.res", 64'(result), 64'(32'h1001));
        check("stall.hold1.ready", 64'(in_ready), 64'(0));
        out_ready = 1'b1;
        #1;
        check("stall.release_ready", 64'(in_ready), 64'(1));
        tick();
        in_valid = 1'b0;
        check("drain.op2", 64'(result), 64'(32'h1002));
        tick();
        check("drain.op3", 64'(result), 64'(32'h1003));
        check("drain.op3.valid", 64'(out_valid), 64'(1));
        tick();
        check("drain.empty", 64'(out_valid), 64'(0));

        // Reset with two operations in flight
        in_valid = 1'b1; a = 32'h7FFF_FFFF; b = 32'h1; opc = ADD;
        tick();
        a = 32'h7FFF_FFF0;
        tick();
        check("flight.valid", 64'(out_valid), 64'(1));
        in_valid = 1'b0; reset = 1'b1;
        tick();
        check("flight.rst.valid", 64'(out_valid), 64'(0));
        check("flight.rst.result", 64'(result), 64'(0));
        check("flight.rst.flags", 64'({ovf, lt, ne}), 64'(0));
`ifdef ALU_PIPE_STICKY_OVF_EN
        check("sticky.cleared", 64'(sticky), 64'(0));
`endif
        reset = 1'b0;
        tick();
        check("flight.discard1", 64'(out_valid), 64'(0));
        tick();
        check("flight.discard2", 64'(out_valid), 64'(0));

        // 16-bit instance
        op16(16'hFFFF, 16'h0001, ADD);
        check("w16.add.valid", 64'(ov16), 64'(1));
        check("w16.add.result", 64'(result16), 64'(16'h0000));
        check("w16.add.ovf", 64'(ovf16), 64'(0));
        check("w16.add.lt", 64'(lt16), 64'(1));
        op16(16'h0005, 16'h0003, 5'b01111);
        check("w16.illegal.result", 64'(result16), 64'(0));
        check("w16.illegal.ovf", 64'(ovf16), 64'(0));
        check("w16.illegal.ne", 64'(ne16), 64'(1));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
